// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative RV32M multiply/divide unit for the EX stage.
//                Radix-2 shift-add multiply and restoring divide, one bit per
//                cycle, with an optional single-cycle path for divide-by-zero
//                and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit FAST_PATH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic               sa_q;      // dividend / multiplicand was negative
    logic               neg_q;     // product or quotient must be negated
    logic [WIDTH-1:0]   m_q;       // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] prod_q;    // mul: {acc, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]   result_q;
    logic               done_q;

    // Operand conditioning at start: sign detection, magnitudes, fast-path results
    logic               w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic               w_fp_hit;
    logic [WIDTH-1:0]   w_fp_val;
    always_comb begin
        w_is_div = funct3[2];
        w_sgn_a  = w_is_div ? ~funct3[0] : (funct3 != 3'b011);
        w_sgn_b  = w_is_div ? ~funct3[0] : ~funct3[1];
        w_neg_a  = w_sgn_a & rs1[WIDTH-1];
        w_neg_b  = w_sgn_b & rs2[WIDTH-1];
        w_abs_a  = w_neg_a ? -rs1 : rs1;
        w_abs_b  = w_neg_b ? -rs2 : rs2;
        // A zero divisor yields an all-ones quotient regardless of signs
        w_neg    = (w_neg_a ^ w_neg_b) & ~(w_is_div & (rs2 == '0));
        w_fp_hit = 1'b0;
        w_fp_val = '0;
        if (FAST_PATH && w_is_div) begin
            if (rs2 == '0) begin
                w_fp_hit = 1'b1;
                w_fp_val = funct3[1] ? rs1 : '1;
            end else if (!funct3[0] && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1)) begin
                w_fp_hit = 1'b1;
                w_fp_val = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
            end
        end
    end

    // One iteration of shift-add multiply and restoring divide
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_t;
    logic [WIDTH+1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_step_d;
    always_comb begin
        w_mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, m_q} : '0);
        w_div_t    = prod_q[2*WIDTH-1:WIDTH-1];
        // Extra guard bit: with a zero divisor the partial remainder can reach 2^(W+1)-1
        w_div_diff = {1'b0, w_div_t} - {2'b00, m_q};
        w_div_ge   = ~w_div_diff[WIDTH+1];
        if (op_q[2]) begin
            w_step_d = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_t[WIDTH-1:0]),
                        prod_q[WIDTH-2:0], w_div_ge};
        end else begin
            w_step_d = {w_mul_sum, prod_q[WIDTH-1:1]};
        end
    end

    // Sign correction and result selection for the FIX cycle
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s, w_rem_s, w_fix_d;
    always_comb begin
        w_prod_s = neg_q ? -prod_q : prod_q;
        w_quo_s  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        w_rem_s  = sa_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 w_fix_d = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix_d = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_fix_d = w_quo_s;
            default:                w_fix_d = w_rem_s;
        endcase
    end

    // Stall request is raised in the accepting IDLE cycle without waiting for a clock
    assign busy   = (state_q == S_CALC) || (state_q == S_FIX) ||
                    ((state_q == S_IDLE) && start && !kill && !rst);
    assign done   = done_q;
    assign result = result_q;

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_q   <= funct3;
                        sa_q   <= w_neg_a;
                        neg_q  <= w_neg;
                        m_q    <= w_is_div ? w_abs_b : w_abs_a;
                        prod_q <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                        cnt_q  <= '0;
                        if (w_fp_hit) begin
                            result_q <= w_fp_val;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        prod_q <= w_step_d;
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= w_fix_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
